// File: rtl/port_alloc.sv
`default_nettype none
// ============================================================================
// Module      : port_alloc
// Description : Two-stage age-ordered output port allocator for a 4-port
//               bufferless deflection router. Stage 1 registers the incoming
//               flits. The allocation result is computed combinationally from
//               stage 1 and registered onto the outputs, so the latency is two
//               cycles.
//               Flits are ranked oldest first. A tie in age goes to the lower
//               input index. Each flit takes its lowest free productive port.
//               A flit with no free productive port is deflected to the lowest
//               free port. A multicast flit may fork onto further free
//               productive ports. It does so only while enough ports remain
//               for every lower-ranked flit.
//               A saturating counter accumulates the number of deflections.
// Ports       : clk       - rising-edge clock
//               reset     - synchronous active-high reset
//               in_valid  - [3:0] flit present on input i
//               in_age    - [4*AGE_W-1:0] age of flit i, larger is older
//               in_ppv    - [15:0] productive port vector of flit i (N,E,S,W)
//               in_mc     - [3:0] flit i is multicast
//               out_valid - [3:0] output p carries a flit
//               out_src   - [7:0] input index driving output p (2 bits/port)
//               out_defl  - [3:0] flit on output p is deflected
//               defl_cnt  - [CNT_W-1:0] saturating deflection count
// Revision    : 1.0 - initial release
// ============================================================================
module port_alloc #(
    parameter int AGE_W = 8,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           in_valid,
    input  logic [4*AGE_W-1:0]   in_age,
    input  logic [15:0]          in_ppv,
    input  logic [3:0]           in_mc,
    output logic [3:0]           out_valid,
    output logic [7:0]           out_src,
    output logic [3:0]           out_defl,
    output logic [CNT_W-1:0]     defl_cnt
);

    // ------------------------------------------------------------------
    // Stage 1: capture inputs. The fields of invalid slices are zeroed here,
    // so later logic never sees stale age, PPV or multicast bits.
    // ------------------------------------------------------------------
    logic [3:0]         s1_valid_q;
    logic [4*AGE_W-1:0] s1_age_q;
    logic [15:0]        s1_ppv_q;
    logic [3:0]         s1_mc_q;

    logic [4*AGE_W-1:0] age_gated;
    logic [15:0]        ppv_gated;
    logic [3:0]         mc_gated;

    always_comb begin
        age_gated = '0;
        ppv_gated = '0;
        mc_gated  = '0;
        for (int i = 0; i < 4; i++) begin
            if (in_valid[i]) begin
                age_gated[i*AGE_W +: AGE_W] = in_age[i*AGE_W +: AGE_W];
                ppv_gated[i*4 +: 4]         = in_ppv[i*4 +: 4];
                mc_gated[i]                 = in_mc[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= '0;
            s1_age_q   <= '0;
            s1_ppv_q   <= '0;
            s1_mc_q    <= '0;
        end else begin
            s1_valid_q <= in_valid;
            s1_age_q   <= age_gated;
            s1_ppv_q   <= ppv_gated;
            s1_mc_q    <= mc_gated;
        end
    end

    // ------------------------------------------------------------------
    // Ranking: the rank of a flit is the number of valid flits that beat it.
    // Valid flits form a strict total order, so their ranks are distinct.
    // The rank of an invalid slice is never used.
    // ------------------------------------------------------------------
    logic [1:0] rank [4];
    logic [2:0] nvalid;

    always_comb begin
        nvalid = '0;
        for (int i = 0; i < 4; i++) begin
            nvalid = nvalid + {2'b00, s1_valid_q[i]};
        end
        for (int i = 0; i < 4; i++) begin
            rank[i] = '0;
            for (int j = 0; j < 4; j++) begin
                if (j != i && s1_valid_q[j] &&
                    ((s1_age_q[j*AGE_W +: AGE_W] > s1_age_q[i*AGE_W +: AGE_W]) ||
                     ((s1_age_q[j*AGE_W +: AGE_W] == s1_age_q[i*AGE_W +: AGE_W]) && (j < i)))) begin
                    rank[i] = rank[i] + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Allocation in rank order.
    // ------------------------------------------------------------------
    logic [3:0]       free;
    logic [2:0]       nfree;
    logic [2:0]       lower;
    logic             taken;
    logic [3:0]       out_valid_d;
    logic [7:0]       out_src_d;
    logic [3:0]       out_defl_d;

    always_comb begin
        free        = 4'hF;
        nfree       = 3'd4;
        lower       = '0;
        taken       = 1'b0;
        out_valid_d = '0;
        out_src_d   = '0;
        out_defl_d  = '0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                if (s1_valid_q[i] && (rank[i] == r[1:0])) begin
                    // Number of valid flits still waiting after this one.
                    lower = nvalid - 3'd1 - r[2:0];
                    taken = 1'b0;
                    // First productive grant.
                    for (int p = 0; p < 4; p++) begin
                        if (!taken && free[p] && s1_ppv_q[i*4 + p]) begin
                            free[p]              = 1'b0;
                            nfree                = nfree - 3'd1;
                            out_valid_d[p]       = 1'b1;
                            out_src_d[p*2 +: 2]  = i[1:0];
                            out_defl_d[p]        = 1'b0;
                            taken                = 1'b1;
                        end
                    end
                    // Multicast fork. An extra copy is taken only when the
                    // ports left over still cover every lower-ranked flit.
                    if (taken && s1_mc_q[i]) begin
                        for (int p = 0; p < 4; p++) begin
                            if (free[p] && s1_ppv_q[i*4 + p] &&
                                ((nfree - 3'd1) >= lower)) begin
                                free[p]             = 1'b0;
                                nfree               = nfree - 3'd1;
                                out_valid_d[p]      = 1'b1;
                                out_src_d[p*2 +: 2] = i[1:0];
                                out_defl_d[p]       = 1'b0;
                            end
                        end
                    end
                    // Deflection. A free port always exists here, because
                    // the flits never outnumber the ports and a fork never
                    // takes a port that a later flit still needs.
                    if (!taken) begin
                        for (int p = 0; p < 4; p++) begin
                            if (!taken && free[p]) begin
                                free[p]             = 1'b0;
                                nfree               = nfree - 3'd1;
                                out_valid_d[p]      = 1'b1;
                                out_src_d[p*2 +: 2] = i[1:0];
                                out_defl_d[p]       = 1'b1;
                                taken               = 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating deflection counter.
    // ------------------------------------------------------------------
    logic [2:0]       defl_pc;
    logic [CNT_W:0]   defl_sum;
    logic [CNT_W-1:0] defl_cnt_d;

    always_comb begin
        defl_pc    = {2'b00, out_defl_d[0]} + {2'b00, out_defl_d[1]} +
                     {2'b00, out_defl_d[2]} + {2'b00, out_defl_d[3]};
        defl_sum   = {1'b0, defl_cnt} + {{(CNT_W-2){1'b0}}, defl_pc};
        defl_cnt_d = defl_sum[CNT_W] ? {CNT_W{1'b1}} : defl_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= '0;
            out_src   <= '0;
            out_defl  <= '0;
            defl_cnt  <= '0;
        end else begin
            out_valid <= out_valid_d;
            out_src   <= out_src_d;
            out_defl  <= out_defl_d;
            defl_cnt  <= defl_cnt_d;
        end
    end

endmodule
`default_nettype wire
